// File: rtl/ram_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the wait-stated RAM controller: default bus widths,
// the wait-state counter width and the controller FSM encoding.
// ----------------------------------------------------------------------------
package ram_ctrl_pkg;

    localparam int D_WIDTH_DEF     = 8;   // data bus width
    localparam int A_WIDTH_DEF     = 8;   // address width (depth = 2**a_width)
    localparam int WAIT_CYCLES_DEF = 2;   // wait states between capture and access
    localparam int CNT_W           = 4;   // wait counter width, covers 0..15

    // Controller FSM encoding (2-bit, fixed so it matches the cache side's view).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Even parity of an 8-bit slice, used by the bench-facing helper and
    // handy for anyone building a wider parity tree from byte lanes.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_array.sv
// ----------------------------------------------------------------------------
// ram_array
// Storage for the RAM controller: 2**a_width words of d_width bits with a
// synchronous write port, a registered read port and a synchronous clear of
// every word.
//
// Optional feature: RAM_CTRL_PARITY_EN adds a parity column. Each write stores
// ^wdata ^ winj; each read compares the stored parity against the word and
// raises perr for that one access.
//
// Ports
//   clk    in   1        clock
//   clr    in   1        synchronous active-low clear (array, read reg, perr)
//   we     in   1        write strobe (one cycle)
//   re     in   1        read strobe (one cycle)
//   addr   in   a_width  word address
//   wdata  in   d_width  write data
//   winj   in   1        invert stored parity on this write
//   rdata  out  d_width  registered read data, held until next read / clear
//   perr   out  1        parity mismatch on the read just performed
// ----------------------------------------------------------------------------
module ram_array #(
    parameter int d_width = 8,
    parameter int a_width = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               we,
    input  logic               re,
    input  logic [a_width-1:0] addr,
    input  logic [d_width-1:0] wdata,
    input  logic               winj,
    output logic [d_width-1:0] rdata,
    output logic               perr
);

    localparam int DEPTH = 2 ** a_width;

    logic [d_width-1:0] mem [DEPTH];

    // NOTE: the array is cleared word by word on clr, so it maps to flops
    // rather than a RAM macro; a macro could not honour a full-array clear.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only changes on a read access, so the bus keeps showing
    // the last read value between reads.
    always_ff @(posedge clk) begin
        if (!clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

`ifdef RAM_CTRL_PARITY_EN
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                par[i] <= 1'b0;
            end
        end else if (we) begin
            par[addr] <= (^wdata) ^ winj;
        end
    end

    // perr is a one-access flag: set alongside the read, cleared on every
    // other edge, which puts it in step with the rdy strobe.
    always_ff @(posedge clk) begin
        if (!clr) begin
            perr <= 1'b0;
        end else begin
            perr <= re & ((^mem[addr]) != par[addr]);
        end
    end
`else
    logic unused_winj;
    assign unused_winj = winj;
    assign perr        = 1'b0;
`endif

endmodule

// File: rtl/ram_ctrl.sv
// ----------------------------------------------------------------------------
// ram_ctrl
// Memory-side controller sitting below the 4-entry LRU cache. It captures a
// request from the cache's miss/write-through bus, waits wait_cycles states,
// performs the access on ram_array and returns a one-cycle rdy strobe. Read
// data is driven back onto the shared bidirectional data bus.
//
// Optional feature: define RAM_CTRL_PARITY_EN to store a parity bit per word
// and report perr with rdy on reads (perr_inj corrupts the stored parity).
// Without it perr is tied to 0 and perr_inj is ignored.
//
// Ports
//   clk       in     1        clock
//   clr       in     1        synchronous active-low clear, beats everything
//   addr      in     a_width  request address
//   data      inout  d_width  shared bus: cache drives on writes, we on reads
//   rw        in     1        1 = read, 0 = write
//   ce        in     1        request enable, held until rdy
//   perr_inj  in     1        invert stored parity on this write
//   rdy       out    1        one-cycle completion strobe
//   perr      out    1        parity error, valid with rdy on reads
// ----------------------------------------------------------------------------
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int d_width     = D_WIDTH_DEF,
    parameter int a_width     = A_WIDTH_DEF,
    parameter int wait_cycles = WAIT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [a_width-1:0] addr,
    inout  wire  [d_width-1:0] data,
    input  logic               rw,
    input  logic               ce,
    input  logic               perr_inj,
    output logic               rdy,
    output logic               perr
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(wait_cycles);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [a_width-1:0] a_q;
    logic [d_width-1:0] wd_q;
    logic               rw_q;
    logic               inj_q;
    logic               access;
    logic               we;
    logic               re;
    logic [d_width-1:0] rd_data;
    logic               oe;

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (ce) begin
                    state_nxt = (wait_cycles == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!ce) begin
                    state_nxt = ST_IDLE;          // abort
                end else if (cnt == CNT_ONE) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_nxt = ce ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                // ce is deliberately ignored here so a held ce cannot retrigger
                // on the same request.
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The access happens only if the request is still alive at the ACCESS edge.
    assign access = (state == ST_ACCESS) && ce;
    assign we     = access && !rw_q;
    assign re     = access &&  rw_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and completion strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt   <= '0;
            rdy   <= 1'b0;
            a_q   <= '0;
            wd_q  <= '0;
            rw_q  <= 1'b0;
            inj_q <= 1'b0;
        end else begin
            rdy <= access;
            case (state)
                ST_IDLE: begin
                    if (ce) begin
                        a_q   <= addr;
                        wd_q  <= data;
                        rw_q  <= rw;
                        inj_q <= perr_inj;
                        cnt   <= CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    ram_array #(
        .d_width (d_width),
        .a_width (a_width)
    ) u_array (
        .clk   (clk),
        .clr   (clr),
        .we    (we),
        .re    (re),
        .addr  (a_q),
        .wdata (wd_q),
        .winj  (inj_q),
        .rdata (rd_data),
        .perr  (perr)
    );

    // ------------------------------------------------------------------
    // Bus drive: only while the cache is asking for a read and no clear is
    // in progress; with rw=0 the cache owns the bus and we stay off it.
    // ------------------------------------------------------------------
    assign oe = rw & ce & clr;

    for (genvar i = 0; i < d_width; i++) begin : g_bus
        bufif1 u_buf (data[i], rd_data[i], oe);
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ram_ctrl
// Self-checking bench for ram_ctrl (wait_cycles = 2). A table of requests with
// their expected read data / parity flag is applied in a loop; each request
// pushes its expectation onto a scoreboard queue that is popped when rdy
// arrives. Hand-written sequences cover held ce, aborts and mid-access clear.
// ----------------------------------------------------------------------------
module tb_ram_ctrl;

    localparam int WAIT_CYCLES = 2;
    localparam int LAT         = WAIT_CYCLES + 2;  // edges from ce to rdy visible
    localparam int PERIOD      = WAIT_CYCLES + 3;  // edges per request
`ifdef RAM_CTRL_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] addr;
    logic       rw;
    logic       ce;
    logic       perr_inj;
    logic       rdy;
    logic       perr;
    wire  [7:0] data;
    logic [7:0] tb_d;
    logic       tb_oe;

    assign data = tb_oe ? tb_d : 8'hzz;

    ram_ctrl #(
        .d_width     (8),
        .a_width     (8),
        .wait_cycles (WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .addr     (addr),
        .data     (data),
        .rw       (rw),
        .ce       (ce),
        .perr_inj (perr_inj),
        .rdy      (rdy),
        .perr     (perr)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string      name;
        bit         rd;
        logic [7:0] a;
        logic [7:0] wd;
        bit         inj;
        logic [7:0] exp_d;
        bit         exp_pe;
    } vec_t;

    typedef struct {
        string      name;
        bit         rd;
        logic [7:0] d;
        bit         pe;
    } exp_t;

    exp_t sb_q[$];

    // Drive one complete request from a negedge, wait (bounded) for rdy,
    // compare against the scoreboard, then let DONE pass.
    task automatic do_req(input vec_t v);
        exp_t e;
        int   n;
        bit   got;
        e.name = v.name;
        e.rd   = v.rd;
        e.d    = v.exp_d;
        e.pe   = v.exp_pe & PARITY;
        sb_q.push_back(e);

        rw       = v.rd;
        addr     = v.a;
        tb_d     = v.wd;
        tb_oe    = !v.rd;
        perr_inj = v.inj;
        ce       = 1'b1;

        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = rdy;
        end
        check({v.name, "_latency"}, n, LAT);

        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.rd) begin
                check({e.name, "_data"}, data, e.d);
                check({e.name, "_perr"}, perr, e.pe);
            end
        end

        ce       = 1'b0;
        tb_oe    = 1'b0;
        perr_inj = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({v.name, "_rdy_pulse"}, rdy, 1'b0);
    endtask

    // Count rdy pulses over a number of edges, sampling at negedges.
    task automatic count_rdy(input int edges, output int pulses);
        pulses = 0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy) pulses++;
        end
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input bit rd, input logic [7:0] a,
                                input logic [7:0] wd, input bit inj,
                                input logic [7:0] exp_d, input bit exp_pe);
        vec_t v;
        v.name = name; v.rd = rd; v.a = a; v.wd = wd; v.inj = inj;
        v.exp_d = exp_d; v.exp_pe = exp_pe;
        return v;
    endfunction

    initial begin
        int   pulses;
        int   edge_q[$];

        vecs.push_back(mk("clr_rd_00",  1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("clr_rd_ff",  1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("wr_3c",      1'b0, 8'h3C, 8'hA5, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("rd_3c",      1'b1, 8'h3C, 8'h00, 1'b0, 8'hA5, 1'b0));
        vecs.push_back(mk("wr_3d",      1'b0, 8'h3D, 8'h5A, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("rd_3d",      1'b1, 8'h3D, 8'h00, 1'b0, 8'h5A, 1'b0));
        vecs.push_back(mk("rd_3c_again",1'b1, 8'h3C, 8'h00, 1'b0, 8'hA5, 1'b0));
        vecs.push_back(mk("wr_20_inj",  1'b0, 8'h20, 8'h0F, 1'b1, 8'h00, 1'b0));
        vecs.push_back(mk("rd_20_perr", 1'b1, 8'h20, 8'h00, 1'b0, 8'h0F, 1'b1));
        vecs.push_back(mk("wr_21",      1'b0, 8'h21, 8'h33, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("rd_21_clean",1'b1, 8'h21, 8'h00, 1'b0, 8'h33, 1'b0));
        vecs.push_back(mk("wr_ff",      1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0));
        vecs.push_back(mk("rd_ff",      1'b1, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0));

        // Reset
        clr = 1'b0; ce = 1'b0; rw = 1'b0; addr = '0; perr_inj = 1'b0;
        tb_d = '0; tb_oe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rdy",  rdy,  1'b0);
        check("reset_perr", perr, 1'b0);
        clr = 1'b1;
        @(negedge clk);

        // Table-driven requests
        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i]);
        end

        // Held ce: read 0x3C for 15 edges -> rdy at edges 4, 9, 14 only
        rw = 1'b1; addr = 8'h3C; ce = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                edge_q.push_back(i);
                check("held_data", data, 8'hA5);
            end
        end
        ce = 1'b0;
        check("held_count", edge_q.size(), 3);
        for (int k = 0; k < edge_q.size(); k++) begin
            check("held_edge", edge_q[k], LAT + PERIOD * k);
        end
        repeat (2) @(negedge clk);

        // Abort in WAIT: write 0x11 to 0x05, drop ce after T1
        rw = 1'b0; addr = 8'h05; tb_d = 8'h11; tb_oe = 1'b1; ce = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        ce = 1'b0; tb_oe = 1'b0;
        count_rdy(8, pulses);
        check("abort_wait_rdy", pulses, 0);

        // Abort at ACCESS: write 0x22 to 0x06, drop ce after T2
        rw = 1'b0; addr = 8'h06; tb_d = 8'h22; tb_oe = 1'b1; ce = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        ce = 1'b0; tb_oe = 1'b0;
        count_rdy(8, pulses);
        check("abort_access_rdy", pulses, 0);

        do_req(mk("rd_05_after_abort", 1'b1, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0));
        do_req(mk("rd_06_after_abort", 1'b1, 8'h06, 8'h00, 1'b0, 8'h00, 1'b0));

        // Mid-access clear
        do_req(mk("wr_10", 1'b0, 8'h10, 8'h77, 1'b0, 8'h00, 1'b0));
        do_req(mk("rd_10", 1'b1, 8'h10, 8'h00, 1'b0, 8'h77, 1'b0));
        rw = 1'b1; addr = 8'h10; ce = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        clr = 1'b0;                       // lands on a WAIT edge
        @(posedge clk);
        @(negedge clk);
        check("midclr_rdy", rdy, 1'b0);
        check("midclr_perr", perr, 1'b0);
        clr = 1'b1; ce = 1'b0;
        count_rdy(6, pulses);
        check("midclr_no_rdy", pulses, 0);
        do_req(mk("rd_10_after_clr", 1'b1, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0));
        do_req(mk("rd_3c_after_clr", 1'b1, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0));

        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
